// File: rtl/axi_lite_rr_master.sv
// Round-robin share of one AXI4-Lite slave among NREQ req/ack clients, one transaction in flight.
// Valids rise 1 cycle after grant, ack pulses 1 cycle in DONE; slave stalls just hold the current state.
module axi_lite_rr_master #(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      ack_rdata,
  output logic [1:0]         ack_resp,
  output logic [AW-1:0]      awaddr,
  output logic               awvalid,
  input  logic               awready,
  output logic [DW-1:0]      wdata,
  output logic [DW/8-1:0]    wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  output logic [AW-1:0]      araddr,
  output logic               arvalid,
  input  logic               arready,
  input  logic [DW-1:0]      rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] last_gnt;
  logic [GW-1:0] gnt;
  logic [GW-1:0] arb_idx;
  logic          arb_any;
  int            best_d;
  int            cand_d;
  logic          aw_done, w_done;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          aw_fin, w_fin;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  // Writes are always full-word.
  assign wstrb = '1;

  // Pick the requester with the smallest rotational distance after last_gnt.
  always_comb begin
    arb_idx = '0;
    arb_any = |req;
    best_d  = NREQ;
    cand_d  = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j]) begin
        cand_d = (j + NREQ - int'(last_gnt) - 1) % NREQ;
        if (cand_d < best_d) begin
          best_d  = cand_d;
          arb_idx = GW'(j);
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = req_we[arb_idx] ? WR_AW_W : RD_AR;
      WR_AW_W: if (aw_fin && w_fin) state_nxt = WR_B;
      WR_B:    if (b_hs) state_nxt = DONE;
      RD_AR:   if (ar_hs) state_nxt = RD_R;
      RD_R:    if (r_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_gnt  <= GW'(NREQ - 1);
      gnt       <= '0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ack       <= '0;
      ack_rdata <= '0;
      ack_resp  <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt      <= arb_idx;
            last_gnt <= arb_idx;
            if (req_we[arb_idx]) begin
              awaddr  <= req_addr[arb_idx*AW +: AW];
              wdata   <= req_wdata[arb_idx*DW +: DW];
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              araddr  <= req_addr[arb_idx*AW +: AW];
              arvalid <= 1'b1;
            end
          end
        end
        WR_AW_W: begin
          // AW and W complete independently; B is only accepted once both have.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) bready <= 1'b1;
        end
        WR_B: begin
          if (b_hs) begin
            bready    <= 1'b0;
            ack_rdata <= '0;
            ack_resp  <= bresp;
            ack[gnt]  <= 1'b1;
          end
        end
        RD_AR: begin
          if (ar_hs) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        RD_R: begin
          if (r_hs) begin
            rready    <= 1'b0;
            ack_rdata <= rdata;
            ack_resp  <= rresp;
            ack[gnt]  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_rr_master.sv
// Directed bench: requester tasks plus a latency-programmable AXI4-Lite slave; a monitor
// pops the expected-ack queue on every ack pulse.
module tb_axi_lite_rr_master;

  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic               aclk = 1'b0;
  logic               areset;
  logic [NREQ-1:0]    req, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      ack_rdata;
  logic [1:0]         ack_resp;
  logic [AW-1:0]      awaddr, araddr;
  logic               awvalid, awready, wvalid, wready, bvalid, bready;
  logic               arvalid, arready, rvalid, rready;
  logic [DW-1:0]      wdata, rdata;
  logic [DW/8-1:0]    wstrb;
  logic [1:0]         bresp, rresp;

  axi_lite_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .aclk(aclk), .areset(areset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .ack_rdata(ack_rdata), .ack_resp(ack_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int passed = 0;
  int total  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   rdata;
    logic [1:0]      resp;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int i, input logic [DW-1:0] rd, input logic [1:0] rs);
    exp_t e;
    e.ack    = '0;
    e.ack[i] = 1'b1;
    e.rdata  = rd;
    e.resp   = rs;
    sb.push_back(e);
  endtask

  // Slave knobs and bookkeeping
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0] b_resp_cfg = 2'b00;
  logic [DW-1:0] mem [16];
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_hs_cnt = 0;
  logic aw_have, w_have, b_pend, r_pend;
  logic [AW-1:0] aw_a, ar_a;
  logic [DW-1:0] w_d;

  // Slave: drives on the falling edge, so valid/ready are stable across each rising edge.
  initial begin
    for (int k = 0; k < 16; k++) mem[k] = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0; aw_a = 0; ar_a = 0; w_d = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        if (!b_pend && aw_have && w_have) begin
          mem[aw_a] = w_d; b_pend = 1; b_cnt = 0; aw_have = 0; w_have = 0;
        end
        if (b_pend) begin
          if (b_cnt >= b_lat) begin bvalid = 1; bresp = b_resp_cfg; end
          else begin bvalid = 0; b_cnt++; end
        end else bvalid = 0;
        if (bvalid && bready) begin b_pend = 0; b_hs_cnt++; end

        if (r_pend) begin
          if (r_cnt >= r_lat) begin rvalid = 1; rdata = mem[ar_a]; rresp = 2'b00; end
          else begin rvalid = 0; r_cnt++; end
        end else rvalid = 0;
        if (rvalid && rready) r_pend = 0;

        if (awvalid && !aw_have) begin
          if (aw_cnt >= aw_lat) awready = 1; else begin awready = 0; aw_cnt++; end
        end else begin awready = 0; aw_cnt = 0; end
        if (awvalid && awready) begin aw_a = awaddr; aw_have = 1; aw_cnt = 0; end

        if (wvalid && !w_have) begin
          if (w_cnt >= w_lat) wready = 1; else begin wready = 0; w_cnt++; end
        end else begin wready = 0; w_cnt = 0; end
        if (wvalid && wready) begin w_d = wdata; w_have = 1; w_cnt = 0; end

        if (arvalid && !r_pend) begin
          if (ar_cnt >= ar_lat) arready = 1; else begin arready = 0; ar_cnt++; end
        end else begin arready = 0; ar_cnt = 0; end
        if (arvalid && arready) begin ar_a = araddr; r_pend = 1; r_cnt = 0; end
      end
    end
  end

  // Monitor: channel-activity counters and scoreboard pop on every ack pulse.
  int early_aw = 0, bwait = 0;
  initial begin
    forever begin
      @(negedge aclk);
      #1;
      if (awvalid === 1'b0 && wvalid === 1'b1) early_aw++;
      if (bready === 1'b1 && bvalid === 1'b0) bwait++;
      if (ack !== '0) begin
        if (sb.size() == 0) chk("unexpected_ack", 64'(ack), 64'(0));
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_vec", 64'(ack), 64'(e.ack));
          chk("ack_rdata", 64'(ack_rdata), 64'(e.rdata));
          chk("ack_resp", 64'(ack_resp), 64'(e.resp));
        end
      end
    end
  end

  // One requester transaction: raise req, wait for its ack, drop req on that cycle.
  task automatic do_txn(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int cyc);
    req_we[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
    cyc = 0;
    do begin
      @(negedge aclk);
      cyc++;
    end while (ack[i] !== 1'b1 && cyc < 200);
    if (cyc >= 200) chk("ack_timeout", 64'(ack[i]), 64'(1));
    req[i] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge aclk);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int cyc, hs0, n;

  initial begin
    areset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    #1;
    chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_addr", 64'({awaddr, araddr}), 64'(0));
    chk("rst_data", 64'({wdata, ack_rdata, ack_resp}), 64'(0));
    chk("rst_wstrb", 64'(wstrb), 64'(4'hF));
    repeat (3) @(negedge aclk);
    areset = 1'b0;

    // 1: write then read back; ack on the 4th cycle counting the IDLE grant cycle.
    push_exp(0, 32'h0, 2'b00);
    do_txn(0, 1'b1, 4'h0, 32'hCAFEBABE, cyc);
    chk("wr_latency", 64'(cyc), 64'(3));
    push_exp(0, 32'hCAFEBABE, 2'b00);
    do_txn(0, 1'b0, 4'h0, 32'h0, cyc);

    // 2: simultaneous requests after reset -> requester 0 first.
    pulse_reset();
    push_exp(0, 32'h0, 2'b00);
    push_exp(1, 32'h0, 2'b00);
    fork
      do_txn(0, 1'b1, 4'h4, 32'h11111111, cyc);
      begin int c1; do_txn(1, 1'b1, 4'h8, 32'h22222222, c1); end
    join

    // 3: four back-to-back writes each -> grants alternate 0,1,0,1,...
    for (int k = 0; k < 4; k++) begin
      push_exp(0, 32'h0, 2'b00);
      push_exp(1, 32'h0, 2'b00);
    end
    fork
      begin int c0; for (int k = 0; k < 4; k++) do_txn(0, 1'b1, 4'h4, 32'hA0000000 + k, c0); end
      begin int c1; for (int k = 0; k < 4; k++) do_txn(1, 1'b1, 4'h8, 32'hB0000000 + k, c1); end
    join
    push_exp(0, 32'hA0000003, 2'b00);
    push_exp(1, 32'hB0000003, 2'b00);
    fork
      begin int c0; do_txn(0, 1'b0, 4'h4, 32'h0, c0); end
      begin int c1; do_txn(1, 1'b0, 4'h8, 32'h0, c1); end
    join

    // 4: wready lags 3 cycles behind awready.
    w_lat = 3; early_aw = 0; hs0 = b_hs_cnt;
    push_exp(0, 32'h0, 2'b00);
    do_txn(0, 1'b1, 4'hC, 32'h12345678, cyc);
    chk("aw_early_cycles", 64'(early_aw), 64'(3));
    chk("b_handshakes", 64'(b_hs_cnt - hs0), 64'(1));
    w_lat = 0;
    push_exp(0, 32'h12345678, 2'b00);
    do_txn(0, 1'b0, 4'hC, 32'h0, cyc);

    // 5: bvalid delayed 5 cycles with SLVERR.
    b_lat = 5; b_resp_cfg = 2'b10; bwait = 0;
    push_exp(1, 32'h0, 2'b10);
    do_txn(1, 1'b1, 4'h8, 32'h5555AAAA, cyc);
    chk("bready_wait_cycles", 64'(bwait), 64'(5));
    b_lat = 0; b_resp_cfg = 2'b00;

    // 6: reset while waiting for read data; transaction abandoned.
    r_lat = 10;
    req_we[1] = 1'b0; req_addr[AW +: AW] = 4'h0; req[1] = 1'b1;
    n = 0;
    while (rready !== 1'b1 && n < 30) begin @(negedge aclk); n++; end
    chk("reached_rd_r", 64'(rready), 64'(1));
    req[1] = 1'b0;
    areset = 1'b1;
    #1;
    chk("midrst_ar_r", 64'({arvalid, rready}), 64'(0));
    chk("midrst_ack", 64'(ack), 64'(0));
    chk("midrst_wr", 64'({awvalid, wvalid, bready}), 64'(0));
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    r_lat = 0;
    push_exp(0, 32'hCAFEBABE, 2'b00);
    push_exp(1, 32'h12345678, 2'b00);
    fork
      begin int c0; do_txn(0, 1'b0, 4'h0, 32'h0, c0); end
      begin int c1; do_txn(1, 1'b0, 4'hC, 32'h0, c1); end
    join

    repeat (5) @(negedge aclk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
